// File: rtl/flash_pkg.sv
// Shared types and helpers for the flash engine arbiter.
// Address width is derived from word width times address words.
package flash_pkg;

  typedef enum logic [1:0] {
    Idle,
    Grant,
    Run,
    Release
  } t_arb_state;

  localparam int DEF_WORD_BITS     = 8;
  localparam int DEF_ADDRESS_WORDS = 3;

  function automatic int addr_width(int wb, int aw);
    return wb * aw;
  endfunction

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flash_arbiter_rr_select.sv
// Combinational round-robin pick: first set request
// at or after the pointer, wrapping to zero.
module rr_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            sum;
  logic [IW-1:0] s;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = 0;
    s      = '0;
    for (int i = 0; i < N; i++) begin
      sum = int'(ptr) + i;
      if (sum >= N) sum = sum - N;
      s = IW'(sum);
      if (!any && req[s]) begin
        any       = 1'b1;
        onehot[s] = 1'b1;
        idx       = s;
      end
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one flash_serial engine.
// One burst per grant, with an enforced enable-low gap.
module flash_arbiter
  import flash_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int WORD_BITS      = DEF_WORD_BITS,
  parameter int ADDRESS_WORDS  = DEF_ADDRESS_WORDS,
  parameter int LEN_BITS       = 8,
  parameter int RELEASE_CYCLES = 4,
  parameter int TIMEOUT        = 65535,
  localparam int A  = addr_width(WORD_BITS, ADDRESS_WORDS),
  localparam int IW = idx_width(NUM_REQ),
  localparam int WW = $clog2(TIMEOUT + 1),
  localparam int RW = $clog2(RELEASE_CYCLES + 1)
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic [NUM_REQ-1:0]            in_req,
  input  logic [NUM_REQ-1:0]            in_read,
  input  logic [NUM_REQ*A-1:0]          in_addr,
  input  logic [NUM_REQ*LEN_BITS-1:0]   in_len,
  input  logic [NUM_REQ*WORD_BITS-1:0]  in_data,
  output logic [NUM_REQ-1:0]            out_grant,
  output logic [WORD_BITS-1:0]          out_data,
  output logic [NUM_REQ-1:0]            out_word_valid,
  output logic [NUM_REQ-1:0]            out_done,
  output logic [NUM_REQ-1:0]            out_error,
  output logic                          out_flash_enable,
  output logic                          out_flash_read,
  output logic [A-1:0]                  out_flash_addr,
  output logic [WORD_BITS-1:0]          out_flash_data,
  input  logic [WORD_BITS-1:0]          in_flash_data,
  input  logic                          in_flash_word_rdy
);

  t_arb_state state_q, state_d;

  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        own_q, own_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 rd_q, rd_d;
  logic [A-1:0]         addr_q, addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [WW-1:0]        wdog_q, wdog_d;
  logic [RW-1:0]        rel_q, rel_d;
  logic [WORD_BITS-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]   wv_q, wv_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 rdy_q;
  logic                 word_ev;
  logic                 go_rel;

  logic [NUM_REQ-1:0]   sel_hot;
  logic [IW-1:0]        sel_idx;
  logic                 sel_any;
  logic [IW-1:0]        ptr_nxt;

  rr_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_sel (
    .req    (in_req),
    .ptr    (ptr_q),
    .onehot (sel_hot),
    .idx    (sel_idx),
    .any    (sel_any)
  );

  assign word_ev = in_flash_word_rdy & ~rdy_q;
  assign cnt_inc = cnt_q + 1'b1;
  assign ptr_nxt = (own_q == IW'(NUM_REQ - 1)) ?
                   '0 : own_q + 1'b1;

  // Enable decodes straight from state so reset drops it at once.
  assign out_flash_enable = (state_q == Run);
  assign out_flash_read   = rd_q;
  assign out_flash_addr   = addr_q;
  assign out_flash_data   = (state_q == Run) ?
    in_data[int'(own_q)*WORD_BITS +: WORD_BITS] : '0;

  assign out_grant      = grant_q;
  assign out_data       = data_q;
  assign out_word_valid = wv_q;
  assign out_done       = done_q;
  assign out_error      = err_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    rel_d   = rel_q;
    data_d  = data_q;
    wv_d    = '0;
    done_d  = '0;
    err_d   = '0;
    go_rel  = 1'b0;

    unique case (state_q)
      Idle: begin
        if (sel_any) begin
          own_d   = sel_idx;
          grant_d = sel_hot;
          rd_d    = in_read[sel_idx];
          addr_d  = in_addr[int'(sel_idx)*A +: A];
          len_d   = in_len[int'(sel_idx)*LEN_BITS +: LEN_BITS];
          state_d = Grant;
        end
      end
      Grant: begin
        cnt_d  = '0;
        wdog_d = '0;
        if (len_q == '0) begin
          done_d = grant_q;
          go_rel = 1'b1;
        end else begin
          state_d = Run;
        end
      end
      Run: begin
        if (!in_req[own_q]) begin
          go_rel = 1'b1;
        end else if (word_ev) begin
          wv_d   = grant_q;
          wdog_d = '0;
          cnt_d  = cnt_inc;
          if (rd_q) data_d = in_flash_data;
          if (cnt_inc == len_q) begin
            done_d = grant_q;
            go_rel = 1'b1;
          end
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          err_d  = grant_q;
          go_rel = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      Release: begin
        if (rel_q == RW'(RELEASE_CYCLES - 1)) begin
          state_d = Idle;
        end else begin
          rel_d = rel_q + 1'b1;
        end
      end
      default: state_d = Idle;
    endcase

    if (go_rel) begin
      state_d = Release;
      rel_d   = '0;
      grant_d = '0;
      ptr_d   = ptr_nxt;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= Idle;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      rd_q    <= 1'b1;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wdog_q  <= '0;
      rel_q   <= '0;
      data_q  <= '0;
      wv_q    <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      rel_q   <= rel_d;
      data_q  <= data_d;
      wv_q    <= wv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= in_flash_word_rdy;
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: directed bursts plus random traffic
// against a burst-level reference model.
module tb_flash_arbiter;

  localparam int N  = 2;
  localparam int WB = 8;
  localparam int AW = 24;
  localparam int LB = 8;
  localparam int RC = 4;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    rd = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*LB-1:0] len = '0;
  logic [N*WB-1:0] idata = '0;
  logic [N-1:0]    grant, wv, done, err;
  logic [WB-1:0]   odata, fdata;
  logic [WB-1:0]   fdin = '0;
  logic            fen, frd;
  logic            rdy = 1'b0;
  logic [AW-1:0]   faddr;

  always #5 clk = ~clk;

  flash_arbiter #(
    .NUM_REQ        (N),
    .WORD_BITS      (WB),
    .ADDRESS_WORDS  (3),
    .LEN_BITS       (LB),
    .RELEASE_CYCLES (RC),
    .TIMEOUT        (TO)
  ) dut (
    .in_clk            (clk),
    .in_rst            (rst),
    .in_req            (req),
    .in_read           (rd),
    .in_addr           (addr),
    .in_len            (len),
    .in_data           (idata),
    .out_grant         (grant),
    .out_data          (odata),
    .out_word_valid    (wv),
    .out_done          (done),
    .out_error         (err),
    .out_flash_enable  (fen),
    .out_flash_read    (frd),
    .out_flash_addr    (faddr),
    .out_flash_data    (fdata),
    .in_flash_data     (fdin),
    .in_flash_word_rdy (rdy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h want %0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // Reference model: burst bookkeeping per clock edge.
  int m_own, m_left, m_quiet, m_gap, m_ptr, m_c;
  bit m_first, m_rprev, m_ev, m_fin;
  logic [N-1:0]  e_grant, e_wv, e_done, e_err;
  logic [WB-1:0] e_data, e_fd;
  logic          e_en, e_rd;
  logic [AW-1:0] e_addr;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_own = -1; m_first = 0; m_gap = 0; m_ptr = 0;
      m_rprev = 0; m_quiet = 0; m_left = 0;
      e_grant = '0; e_wv = '0; e_done = '0; e_err = '0;
      e_data = '0; e_en = 0; e_rd = 1; e_addr = '0;
    end else begin
      m_ev = rdy && !m_rprev;
      m_rprev = rdy;
      m_fin = 0;
      e_wv = '0; e_done = '0; e_err = '0;
      if (m_gap > 0) begin
        m_gap--;
      end else if (m_own < 0) begin
        for (int k = 0; k < N; k++) begin
          m_c = (m_ptr + k) % N;
          if (m_own < 0 && req[m_c]) m_own = m_c;
        end
        if (m_own >= 0) begin
          e_grant = '0;
          e_grant[m_own] = 1'b1;
          e_rd = rd[m_own];
          e_addr = addr[m_own*AW +: AW];
          m_left = int'(len[m_own*LB +: LB]);
          m_first = 1;
        end
      end else if (m_first) begin
        m_first = 0;
        if (m_left == 0) begin
          e_done[m_own] = 1'b1;
          m_fin = 1;
        end else begin
          e_en = 1;
          m_quiet = 0;
        end
      end else if (!req[m_own]) begin
        m_fin = 1;
      end else if (m_ev) begin
        e_wv[m_own] = 1'b1;
        if (e_rd) e_data = fdin;
        m_left--;
        m_quiet = 0;
        if (m_left == 0) begin
          e_done[m_own] = 1'b1;
          m_fin = 1;
        end
      end else begin
        m_quiet++;
        if (m_quiet == TO) begin
          e_err[m_own] = 1'b1;
          m_fin = 1;
        end
      end
      if (m_fin) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
        e_grant = '0;
        e_en = 0;
        m_gap = RC;
      end
    end
  end

  // Per-cycle compare, mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      e_fd = '0;
      if (e_en && m_own >= 0) e_fd = idata[m_own*WB +: WB];
      chk("grant", 64'(grant), 64'(e_grant));
      chk("word_valid", 64'(wv), 64'(e_wv));
      chk("done", 64'(done), 64'(e_done));
      chk("error", 64'(err), 64'(e_err));
      chk("enable", 64'(fen), 64'(e_en));
      chk("flash_read", 64'(frd), 64'(e_rd));
      chk("flash_addr", 64'(faddr), 64'(e_addr));
      chk("out_data", 64'(odata), 64'(e_data));
      chk("flash_data", 64'(fdata), 64'(e_fd));
    end
  end

  // Engine side: record write words while the ready pulse is high.
  logic [WB-1:0] wlog[$];
  initial forever begin
    @(negedge clk);
    if (rst && rdy && fen && !frd) wlog.push_back(fdata);
  end

  int cyc_n = 0;
  int en_cyc = 0;
  int eng_wait = 1;
  int done_n[N];
  int err_n[N];
  int t_done[N];
  int t_grant[N];
  bit stall = 0;
  bit stall_force = 0;
  bit rnd_on = 0;
  bit en_prev = 0;
  logic [N-1:0]  gprev = '0;
  logic [WB-1:0] rq[$];
  logic [WB-1:0] rlog0[$];
  int glog[$];

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        done_n[i]++;
        t_done[i] = cyc_n;
      end
      if (err[i]) err_n[i]++;
      if (done[i] || err[i]) req[i] = 1'b0;
      if (wv[i] && !rd[i]) idata[i*WB +: WB] += 1;
      if (wv[i] && i == 0 && rd[0]) rlog0.push_back(odata);
      if (grant[i] && !gprev[i]) begin
        glog.push_back(i);
        t_grant[i] = cyc_n;
      end
    end
    gprev = grant;
    if (fen) en_cyc++;
    if (fen && !en_prev)
      stall = stall_force ||
              (rnd_on && $urandom_range(0, 9) == 0);
    en_prev = fen;
    if (!fen) begin
      rdy = 1'b0;
      eng_wait = $urandom_range(0, 2);
    end else if (rdy) begin
      rdy = 1'b0;
    end else if (!stall) begin
      if (eng_wait == 0) begin
        rdy = 1'b1;
        fdin = (rq.size() > 0) ? rq.pop_front()
                               : WB'($urandom);
        eng_wait = $urandom_range(0, 2);
      end else begin
        eng_wait--;
      end
    end
    if (rnd_on) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) begin
          rd[i] = 1'($urandom_range(0, 1));
          addr[i*AW +: AW] = AW'($urandom);
          len[i*LB +: LB] = ($urandom_range(0, 49) == 0) ?
            LB'(255) : LB'($urandom_range(0, 5));
          idata[i*WB +: WB] = WB'($urandom);
          req[i] = 1'b1;
        end else if (req[i] && grant[i] && fen &&
                     $urandom_range(0, 99) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic start(int i, bit r, logic [AW-1:0] a,
                       int l, logic [WB-1:0] d);
    rd[i] = r;
    addr[i*AW +: AW] = a;
    len[i*LB +: LB] = LB'(l);
    idata[i*WB +: WB] = d;
    req[i] = 1'b1;
  endtask

  task automatic wait_fin(int i, string nm);
    int base;
    int k;
    base = done_n[i] + err_n[i];
    k = 0;
    while (done_n[i] + err_n[i] == base && k < 2000) begin
      cyc();
      k++;
    end
    chk(nm, 64'(k < 2000), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    repeat (3) cyc();
  endtask

  logic [WB-1:0] exp_rd[3] = '{8'hA1, 8'hA2, 8'hA3};
  int d0, e0, k0;

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_enable", 64'(fen), 64'(0));
    chk("rst_read", 64'(frd), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_wv", 64'(wv), 64'(0));
    chk("rst_data", 64'(odata), 64'(0));
    rst = 1'b1;
    cyc();
    cyc();

    // Single read burst of three words.
    rlog0.delete();
    rq = '{8'hA1, 8'hA2, 8'hA3};
    start(0, 1'b1, 24'h000010, 3, 8'h00);
    wait_fin(0, "t1_wait");
    chk("t1_count", 64'(rlog0.size()), 64'(3));
    if (rlog0.size() == 3)
      for (int k = 0; k < 3; k++)
        chk("t1_word", 64'(rlog0[k]), 64'(exp_rd[k]));
    chk("t1_done", 64'(done_n[0]), 64'(1));
    repeat (8) cyc();

    // Simultaneous requests after reset alternate strictly.
    do_reset();
    glog.delete();
    start(0, 1'b1, 24'h000100, 1, 8'h00);
    start(1, 1'b1, 24'h000200, 1, 8'h00);
    wait_fin(1, "t2_wait_a");
    chk("t2_gap", 64'(t_grant[1] - t_done[0]), 64'(RC + 1));
    repeat (2) cyc();
    start(0, 1'b1, 24'h000300, 1, 8'h00);
    start(1, 1'b1, 24'h000400, 1, 8'h00);
    wait_fin(1, "t2_wait_b");
    chk("t2_ngrant", 64'(glog.size()), 64'(4));
    if (glog.size() == 4) begin
      chk("t2_g0", 64'(glog[0]), 64'(0));
      chk("t2_g1", 64'(glog[1]), 64'(1));
      chk("t2_g2", 64'(glog[2]), 64'(0));
      chk("t2_g3", 64'(glog[3]), 64'(1));
    end
    repeat (8) cyc();

    // Write burst from requester 1.
    wlog.delete();
    d0 = done_n[1];
    start(1, 1'b0, 24'h00ABCD, 2, 8'h58);
    wait_fin(1, "t3_wait");
    chk("t3_count", 64'(wlog.size()), 64'(2));
    if (wlog.size() == 2) begin
      chk("t3_w0", 64'(wlog[0]), 64'(8'h58));
      chk("t3_w1", 64'(wlog[1]), 64'(8'h59));
    end
    chk("t3_done", 64'(done_n[1] - d0), 64'(1));
    repeat (8) cyc();

    // Zero-length burst never enables the engine.
    e0 = en_cyc;
    start(0, 1'b1, 24'h000055, 0, 8'h00);
    wait_fin(0, "t4_wait");
    chk("t4_enable", 64'(en_cyc - e0), 64'(0));
    chk("t4_lat", 64'(t_done[0] - t_grant[0]), 64'(1));
    repeat (8) cyc();

    // Engine stall: timeout, then the other requester is served.
    stall_force = 1'b1;
    d0 = done_n[0];
    k0 = err_n[0];
    start(0, 1'b1, 24'h000077, 3, 8'h00);
    while (!grant[0] && cyc_n < 100000) cyc();
    e0 = en_cyc;
    start(1, 1'b1, 24'h000088, 1, 8'h00);
    wait_fin(0, "t5_wait");
    stall_force = 1'b0;
    chk("t5_err", 64'(err_n[0] - k0), 64'(1));
    chk("t5_nodone", 64'(done_n[0] - d0), 64'(0));
    chk("t5_runlen", 64'(en_cyc - e0), 64'(TO));
    wait_fin(1, "t5_next");
    chk("t5_owner", 64'(glog[$]), 64'(1));
    repeat (8) cyc();

    // Reset in the middle of a read burst.
    rlog0.delete();
    start(0, 1'b1, 24'h000900, 4, 8'h00);
    k0 = 0;
    while (rlog0.size() == 0 && k0 < 200) begin
      cyc();
      k0++;
    end
    chk("t6_first", 64'(rlog0.size()), 64'(1));
    rst = 1'b0;
    #1;
    chk("t6_enable", 64'(fen), 64'(0));
    chk("t6_grant", 64'(grant), 64'(0));
    chk("t6_wv", 64'(wv), 64'(0));
    chk("t6_data", 64'(odata), 64'(0));
    req = '0;
    cyc();
    cyc();
    rst = 1'b1;
    repeat (4) cyc();
    rlog0.delete();
    d0 = done_n[0];
    start(0, 1'b1, 24'h000900, 4, 8'h00);
    wait_fin(0, "t6_wait");
    chk("t6_words", 64'(rlog0.size()), 64'(4));
    chk("t6_done", 64'(done_n[0] - d0), 64'(1));
    repeat (8) cyc();

    // Random traffic against the model.
    rnd_on = 1'b1;
    repeat (6000) cyc();
    rnd_on = 1'b0;
    k0 = 0;
    while ((req != '0 || grant != '0) && k0 < 4000) begin
      cyc();
      k0++;
    end
    chk("drain", 64'(k0 < 4000), 64'(1));
    repeat (8) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
